// File: rtl/butterfly_radix2_if.sv
// Operand, twiddle and result bundle between the FFT sequencer and the radix-2 butterfly.
// The sequencer is the master: it issues bf_go with operands and collects the results on bf_done.
interface butterfly_radix2_if #(
    parameter int DW = 8,
    parameter int WW = 8,
    parameter int OW = 9
);
    logic                 bf_go;
    logic                 bf_done;
    logic signed [WW-1:0] wx;
    logic signed [WW-1:0] wy;
    logic signed [DW-1:0] x1;
    logic signed [DW-1:0] y1;
    logic signed [DW-1:0] x2;
    logic signed [DW-1:0] y2;
    logic signed [OW-1:0] bfx1;
    logic signed [OW-1:0] bfy1;
    logic signed [OW-1:0] bfx2;
    logic signed [OW-1:0] bfy2;

    modport master (
        output bf_go, wx, wy, x1, y1, x2, y2,
        input  bf_done, bfx1, bfy1, bfx2, bfy2
    );

    modport slave (
        input  bf_go, wx, wy, x1, y1, x2, y2,
        output bf_done, bfx1, bfy1, bfx2, bfy2
    );
endinterface

// File: rtl/butterfly_radix2.sv
// Radix-2 DIT butterfly: X1 = A + W*B, X2 = A - W*B with a rounded Q1.WFRAC twiddle.
// Three register stages (capture, complex multiply + round, add/sub + saturate), one result per go.
module butterfly_radix2 #(
    parameter int DW    = 8,
    parameter int WW    = 8,
    parameter int WFRAC = 6,
    parameter int OW    = 9
) (
    input  logic            clk,
    input  logic            rst,
    butterfly_radix2_if.slave bf
);

    localparam int MW   = (DW > WW) ? DW : WW;
    localparam int PW   = 2 * MW + 1;
    localparam int TW   = PW - WFRAC;
    localparam int SWA  = ((TW > DW) ? TW : DW) + 1;
    localparam int SW   = (SWA > OW + 3) ? SWA : OW + 3;
    localparam int RND  = 1 << (WFRAC - 1);

    localparam logic signed [SW-1:0] SAT_HI = SW'((1 << (OW - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_LO = SW'(-(1 << (OW - 1)));

    // stage 0: captured operands
    logic                 v0;
    logic signed [WW-1:0] w_re0;
    logic signed [WW-1:0] w_im0;
    logic signed [DW-1:0] a_re0;
    logic signed [DW-1:0] a_im0;
    logic signed [DW-1:0] b_re0;
    logic signed [DW-1:0] b_im0;

    // stage 1: rounded twiddle product and delayed A
    logic                 v1;
    logic signed [TW-1:0] t_re1;
    logic signed [TW-1:0] t_im1;
    logic signed [DW-1:0] a_re1;
    logic signed [DW-1:0] a_im1;

    logic signed [PW-1:0] b_re_x;
    logic signed [PW-1:0] b_im_x;
    logic signed [PW-1:0] w_re_x;
    logic signed [PW-1:0] w_im_x;
    logic signed [PW-1:0] prod_re;
    logic signed [PW-1:0] prod_im;
    logic signed [PW-1:0] prod_re_rnd;
    logic signed [PW-1:0] prod_im_rnd;
    logic signed [TW-1:0] t_re_c;
    logic signed [TW-1:0] t_im_c;

    logic signed [SW-1:0] a_re_x;
    logic signed [SW-1:0] a_im_x;
    logic signed [SW-1:0] t_re_x;
    logic signed [SW-1:0] t_im_x;
    logic signed [SW-1:0] s1_re;
    logic signed [SW-1:0] s1_im;
    logic signed [SW-1:0] s2_re;
    logic signed [SW-1:0] s2_im;

    function automatic logic signed [OW-1:0] sat(input logic signed [SW-1:0] s);
        logic signed [OW-1:0] r;
        if (s > SAT_HI) begin
            r = OW'(SAT_HI);
        end else if (s < SAT_LO) begin
            r = OW'(SAT_LO);
        end else begin
            r = OW'(s);
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0    <= 1'b0;
            w_re0 <= '0;
            w_im0 <= '0;
            a_re0 <= '0;
            a_im0 <= '0;
            b_re0 <= '0;
            b_im0 <= '0;
        end else begin
            v0 <= bf.bf_go;
            if (bf.bf_go) begin
                w_re0 <= bf.wx;
                w_im0 <= bf.wy;
                a_re0 <= bf.x1;
                a_im0 <= bf.y1;
                b_re0 <= bf.x2;
                b_im0 <= bf.y2;
            end
        end
    end

    // Products are formed at full width so a -2.0 twiddle on -128 operands cannot wrap.
    always_comb begin
        b_re_x      = PW'(b_re0);
        b_im_x      = PW'(b_im0);
        w_re_x      = PW'(w_re0);
        w_im_x      = PW'(w_im0);
        prod_re     = b_re_x * w_re_x - b_im_x * w_im_x;
        prod_im     = b_re_x * w_im_x + b_im_x * w_re_x;
        prod_re_rnd = prod_re + PW'(RND);
        prod_im_rnd = prod_im + PW'(RND);
        t_re_c      = TW'(prod_re_rnd >>> WFRAC);
        t_im_c      = TW'(prod_im_rnd >>> WFRAC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1    <= 1'b0;
            t_re1 <= '0;
            t_im1 <= '0;
            a_re1 <= '0;
            a_im1 <= '0;
        end else begin
            v1    <= v0;
            t_re1 <= t_re_c;
            t_im1 <= t_im_c;
            a_re1 <= a_re0;
            a_im1 <= a_im0;
        end
    end

    always_comb begin
        a_re_x = SW'(a_re1);
        a_im_x = SW'(a_im1);
        t_re_x = SW'(t_re1);
        t_im_x = SW'(t_im1);
        s1_re  = a_re_x + t_re_x;
        s1_im  = a_im_x + t_im_x;
        s2_re  = a_re_x - t_re_x;
        s2_im  = a_im_x - t_im_x;
    end

    // Result registers only move on a valid slot so they hold the last answer between dones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bf.bf_done <= 1'b0;
            bf.bfx1    <= '0;
            bf.bfy1    <= '0;
            bf.bfx2    <= '0;
            bf.bfy2    <= '0;
        end else begin
            bf.bf_done <= v1;
            if (v1) begin
                bf.bfx1 <= sat(s1_re);
                bf.bfy1 <= sat(s1_im);
                bf.bfx2 <= sat(s2_re);
                bf.bfy2 <= sat(s2_im);
            end
        end
    end

endmodule

// File: tb/tb_butterfly_radix2.sv
// Randomized bench for butterfly_radix2 against an integer-arithmetic butterfly model,
// plus directed cases for unit/imaginary twiddles, saturation, rounding and back-to-back issue.
module tb_butterfly_radix2;

    localparam int DW    = 8;
    localparam int WW    = 8;
    localparam int WFRAC = 6;
    localparam int OW    = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    butterfly_radix2_if #(.DW(DW), .WW(WW), .OW(OW)) bf ();

    butterfly_radix2 #(.DW(DW), .WW(WW), .WFRAC(WFRAC), .OW(OW)) dut (
        .clk (clk),
        .rst (rst),
        .bf  (bf)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        int r1;
        int i1;
        int r2;
        int i2;
        int stamp;
    } res_t;

    res_t q[$];
    int   edge_n   = 0;
    int   done_cnt = 0;
    int   last_r1  = 0;
    int   last_i1  = 0;
    int   last_r2  = 0;
    int   last_i2  = 0;

    function automatic int sat_ref(input int v);
        int hi = (1 << (OW - 1)) - 1;
        int lo = -(1 << (OW - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // round half up: floor(p / 2^WFRAC + 1/2)
    function automatic int round_ref(input int p);
        int d = 1 << WFRAC;
        int n = 2 * p + d;
        int q2 = 2 * d;
        int f = n / q2;
        if ((n % q2 != 0) && (n < 0)) f = f - 1;
        return f;
    endfunction

    function automatic res_t model(input int wx, input int wy, input int x1, input int y1,
                                   input int x2, input int y2);
        res_t r;
        int tr = round_ref(x2 * wx - y2 * wy);
        int ti = round_ref(x2 * wy + y2 * wx);
        r.r1 = sat_ref(x1 + tr);
        r.i1 = sat_ref(y1 + ti);
        r.r2 = sat_ref(x1 - tr);
        r.i2 = sat_ref(y1 - ti);
        r.stamp = 0;
        return r;
    endfunction

    always @(posedge clk) begin : issue_mon
        res_t e;
        edge_n++;
        if (!rst && bf.bf_go) begin
            e = model(int'(bf.wx), int'(bf.wy), int'(bf.x1), int'(bf.y1), int'(bf.x2), int'(bf.y2));
            e.stamp = edge_n;
            q.push_back(e);
        end
    end

    always @(negedge clk) begin : result_mon
        res_t e;
        if (rst) begin
            chk("rst_done", int'(bf.bf_done), 0);
            chk("rst_bfx1", int'(bf.bfx1), 0);
            chk("rst_bfy2", int'(bf.bfy2), 0);
            q.delete();
            last_r1 = 0; last_i1 = 0; last_r2 = 0; last_i2 = 0;
        end else if (bf.bf_done) begin
            done_cnt++;
            if (q.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                e = q.pop_front();
                chk("latency", edge_n, e.stamp + 2);
                chk("bfx1", int'(bf.bfx1), e.r1);
                chk("bfy1", int'(bf.bfy1), e.i1);
                chk("bfx2", int'(bf.bfx2), e.r2);
                chk("bfy2", int'(bf.bfy2), e.i2);
                last_r1 = e.r1; last_i1 = e.i1; last_r2 = e.r2; last_i2 = e.i2;
            end
        end else begin
            if (q.size() > 0 && q[0].stamp + 2 <= edge_n) begin
                chk("missing_done", 0, 1);
                void'(q.pop_front());
            end
            chk("hold_bfx1", int'(bf.bfx1), last_r1);
            chk("hold_bfy1", int'(bf.bfy1), last_i1);
            chk("hold_bfx2", int'(bf.bfx2), last_r2);
            chk("hold_bfy2", int'(bf.bfy2), last_i2);
        end
    end

    task automatic drive(input logic go, input int wx, input int wy, input int x1, input int y1,
                         input int x2, input int y2);
        @(negedge clk);
        bf.bf_go = go;
        bf.wx = WW'(wx);
        bf.wy = WW'(wy);
        bf.x1 = DW'(x1);
        bf.y1 = DW'(y1);
        bf.x2 = DW'(x2);
        bf.y2 = DW'(y2);
    endtask

    task automatic drive_idle();
        drive(1'b0, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    endtask

    task automatic run_one(input string tag, input int wx, input int wy, input int x1, input int y1,
                           input int x2, input int y2, input int e1r, input int e1i,
                           input int e2r, input int e2i);
        int n = 0;
        drive(1'b1, wx, wy, x1, y1, x2, y2);
        drive_idle();
        while (!bf.bf_done && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, n, 2);
        chk({tag, "_bfx1"}, int'(bf.bfx1), e1r);
        chk({tag, "_bfy1"}, int'(bf.bfy1), e1i);
        chk({tag, "_bfx2"}, int'(bf.bfx2), e2r);
        chk({tag, "_bfy2"}, int'(bf.bfy2), e2i);
        drive_idle();
        drive_idle();
    endtask

    initial begin
        int cnt;
        int got[3][4];
        byte wr, wi, ar, ai, br, bi;

        bf.bf_go = 1'b0;
        bf.wx = '0; bf.wy = '0; bf.x1 = '0; bf.y1 = '0; bf.x2 = '0; bf.y2 = '0;

        // reset with random activity on the inputs
        rst = 1'b1;
        for (int i = 0; i < 5; i++)
            drive(1'($urandom), $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
        drive_idle();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) drive_idle();

        run_one("w_one",  64,  0, 10,    5,   3,   -2,  13,    3,    7,   7);
        run_one("w_j",     0, 64, 10,    5,   3,   -2,  12,    8,    8,   2);
        run_one("sat",   127,  0, 127, -128, 127, -128, 255, -256, -125, 126);
        run_one("rnd_p",  32,  0,  0,    0,   1,    0,   1,    0,   -1,   0);
        run_one("rnd_n",  32,  0,  0,    0,  -1,    0,   0,    0,    0,   0);

        // back-to-back issue
        drive(1'b1,  64,  0, 10,    5,   3,   -2);
        drive(1'b1,   0, 64, 10,    5,   3,   -2);
        drive(1'b1, 127,  0, 127, -128, 127, -128);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            drive_idle();
            if (bf.bf_done && cnt < 3) begin
                got[cnt][0] = int'(bf.bfx1);
                got[cnt][1] = int'(bf.bfy1);
                got[cnt][2] = int'(bf.bfx2);
                got[cnt][3] = int'(bf.bfy2);
            end
            if (bf.bf_done) cnt++;
        end
        chk("pipe_cnt", cnt, 3);
        chk("pipe0_bfx1", got[0][0], 13);
        chk("pipe0_bfy2", got[0][3], 7);
        chk("pipe1_bfx1", got[1][0], 12);
        chk("pipe1_bfy1", got[1][1], 8);
        chk("pipe2_bfy1", got[2][1], -256);
        chk("pipe2_bfx2", got[2][2], -125);

        // every third cycle with wrapping increments
        wr = 64; wi = 0; ar = 10; ai = 5; br = 3; bi = -2;
        for (int k = 0; k < 24; k++) begin
            drive(1'b1, wr, wi, ar, ai, br, bi);
            drive_idle();
            drive_idle();
            wr += 8'sd10; wi += 8'sd20; ar += 8'sd30; ai += 8'sd40; br += 8'sd50; bi += 8'sd60;
        end

        // random burst, biased toward extreme values
        for (int k = 0; k < 300; k++) begin
            int w0 = ($urandom_range(0, 7) == 0) ? -128 : int'($urandom);
            int w1 = ($urandom_range(0, 7) == 0) ? -128 : int'($urandom);
            int b0 = ($urandom_range(0, 7) == 0) ? -128 : int'($urandom);
            drive(1'($urandom), w0, w1, $urandom, $urandom, b0, $urandom);
        end
        for (int k = 0; k < 4; k++) drive_idle();

        // reset with operations in flight
        drive(1'b1, 64, 0, 1, 2, 3, 4);
        drive(1'b1, 0, 64, 5, 6, 7, 8);
        @(posedge clk);
        #2 rst = 1'b1;
        drive_idle();
        drive_idle();
        rst = 1'b0;
        cnt = done_cnt;
        for (int k = 0; k < 6; k++) drive_idle();
        chk("flush_no_done", done_cnt - cnt, 0);

        run_one("post_rst", 64, 0, 10, 5, 3, -2, 13, 3, 7, 7);
        for (int k = 0; k < 4; k++) drive_idle();
        chk("queue_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
